// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - issue/result bundle between the EX stage and the mult/div unit
interface mult_div_unit_if;
    logic [3:0]  op;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic [31:0] hi_in;
    logic [31:0] lo_in;
    logic        ex_stall;
    logic        flush;
    logic        done;
    logic        busy;
    logic [63:0] result;

    modport master (
        output op, operand_1, operand_2, hi_in, lo_in, ex_stall, flush,
        input  done, busy, result
    );

    modport slave (
        input  op, operand_1, operand_2, hi_in, lo_in, ex_stall, flush,
        output done, busy, result
    );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - single-cycle multiply/accumulate and 32-step restoring divider with result hold
module mult_div_unit #(
    parameter int DIV_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst,
    mult_div_unit_if.slave  mdu
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
    localparam logic [3:0] OP_MUL   = 4'd9;

    localparam logic [4:0] LAST_STEP = 5'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_DONE
    } state_t;

    state_t      state, next_state;
    logic [4:0]  cnt;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [31:0] dvd_raw_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic [63:0] result_q;

    logic        issue;
    logic        done_c;
    logic        busy_c;
    logic [63:0] result_c;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [63:0] acc;
    logic [63:0] mul_res;
    logic        is_mul;

    logic        signed_div;
    logic [31:0] mag_1;
    logic [31:0] mag_2;

    logic [32:0] rem_shift;
    logic        fits;
    logic [31:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] q_fin;
    logic [31:0] r_fin;
    logic [63:0] div_final;

    assign prod_s = $signed({{32{mdu.operand_1[31]}}, mdu.operand_1})
                  * $signed({{32{mdu.operand_2[31]}}, mdu.operand_2});
    assign prod_u = {32'd0, mdu.operand_1} * {32'd0, mdu.operand_2};
    assign acc    = {mdu.hi_in, mdu.lo_in};

    // Multiply-class result; everything wraps modulo 2^64
    always_comb begin
        mul_res = 64'd0;
        is_mul  = 1'b1;
        case (mdu.op)
            OP_MULT, OP_MUL: mul_res = prod_s;
            OP_MULTU:        mul_res = prod_u;
            OP_MADD:         mul_res = acc + prod_s;
            OP_MADDU:        mul_res = acc + prod_u;
            OP_MSUB:         mul_res = acc - prod_s;
            OP_MSUBU:        mul_res = acc - prod_u;
            default:         is_mul  = 1'b0;
        endcase
    end

    // Operand magnitudes for the divider; unsigned divide passes operands through
    assign signed_div = (mdu.op == OP_DIV);
    assign mag_1 = (signed_div && mdu.operand_1[31]) ? (32'd0 - mdu.operand_1) : mdu.operand_1;
    assign mag_2 = (signed_div && mdu.operand_2[31]) ? (32'd0 - mdu.operand_2) : mdu.operand_2;

    // One restoring step: shift {rem,quo} left, subtract divisor when it fits
    assign rem_shift = {rem_q, quo_q[31]};
    assign fits      = (rem_shift >= {1'b0, dvs_q});
    assign rem_next  = fits ? (rem_shift[31:0] - dvs_q) : rem_shift[31:0];
    assign quo_next  = {quo_q[30:0], fits};
    assign q_fin     = q_neg_q ? (32'd0 - quo_next) : quo_next;
    assign r_fin     = r_neg_q ? (32'd0 - rem_next) : rem_next;
    assign div_final = (dvs_q == 32'd0) ? {dvd_raw_q, 32'hFFFF_FFFF} : {r_fin, q_fin};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode; flush wins over stall and completion
    always_comb begin
        next_state = state;
        done_c     = 1'b0;
        busy_c     = 1'b0;
        result_c   = 64'd0;
        issue      = 1'b0;
        case (state)
            S_IDLE: begin
                if (is_mul) begin
                    done_c   = 1'b1;
                    result_c = mul_res;
                end else if ((mdu.op == OP_DIV || mdu.op == OP_DIVU) && !mdu.flush) begin
                    issue      = 1'b1;
                    next_state = S_DIV;
                end
            end
            S_DIV: begin
                busy_c = 1'b1;
                if (mdu.flush) begin
                    next_state = S_IDLE;
                end else if (cnt == LAST_STEP) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                done_c   = 1'b1;
                result_c = result_q;
                if (mdu.flush || !mdu.ex_stall) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Divider datapath: load on issue, iterate in DIV, capture the final result on the last step
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 5'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            dvs_q     <= 32'd0;
            dvd_raw_q <= 32'd0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            result_q  <= 64'd0;
        end else if (mdu.flush) begin
            cnt <= 5'd0;
        end else if (issue) begin
            cnt       <= 5'd0;
            rem_q     <= 32'd0;
            quo_q     <= mag_1;
            dvs_q     <= mag_2;
            dvd_raw_q <= mdu.operand_1;
            q_neg_q   <= signed_div && (mdu.operand_1[31] ^ mdu.operand_2[31]);
            r_neg_q   <= signed_div && mdu.operand_1[31];
        end else if (state == S_DIV) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt   <= cnt + 5'd1;
            if (cnt == LAST_STEP) begin
                result_q <= div_final;
            end
        end
    end

    assign mdu.done   = done_c;
    assign mdu.busy   = busy_c;
    assign mdu.result = result_c;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Multiply/divide unit that sits directly upstream of the EX stage. It supplies the 64-bit mult/div result and the done flag that EX uses to write HI/LO and to generate its stall request. Multiplies and multiply-accumulates finish combinationally in the issue cycle. Divides use a 32-iteration restoring divider with a hold state, so the result survives downstream pipeline stalls.

Parameters:
DIV_CYCLES, 32, number of iteration cycles; fixed at 32 for 32-bit operands; not intended to be changed.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
op  input  4  decoded op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU, 9 MUL; 10-15 treated as NONE
operand_1  input  32  multiplicand / dividend (rs)
operand_2  input  32  multiplier / divisor (rt)
hi_in  input  32  current HI, accumulate source for MADD/MSUB
lo_in  input  32  current LO, accumulate source for MADD/MSUB
ex_stall  input  1  pipeline held at EX by a later stage; EX will not advance this cycle
flush  input  1  exception/flush; abandons any division in progress
done  output  1  result valid this cycle
busy  output  1  division in progress (state DIV)
result  output  64  {HI, LO}; product/accumulate for multiply class, {remainder, quotient} for divide

Behaviour:
- Only one clock and one reset: clk; rst is synchronous, active-high.
- States: IDLE, DIV, DONE.
- Reset: state IDLE, iteration counter 0, all datapath registers 0; done=0, busy=0, result=0 (if op=NONE).
- IDLE:
  - Multiply class (1,2,5-9): done=1 combinationally, same cycle; no state change.
    - MULT, MUL: signed 32x32->64.
    - MULTU: unsigned.
    - MADD: {hi_in,lo_in} + signed product. MADDU: + unsigned product.
    - MSUB: {hi_in,lo_in} - signed product. MSUBU: - unsigned product.
    - All accumulate arithmetic is modulo 2^64.
  - DIV/DIVU, flush=0: at the clock edge, latch the operand magnitudes (DIV: abs() with quotient/remainder sign flags) and the raw operand_1; go to DIV with counter=0. done=0 this cycle.
  - NONE: done=0, result=0.
- DIV:
  - busy=1, done=0, result=0.
  - op and operands are ignored; the latched copies are used.
  - One restoring step per cycle: shift {rem,quo} left 1; subtract the divisor when rem >= divisor.
  - After the 32nd step (counter 31) go to DONE.
  - Issue edge to first done=1 cycle = 33 cycles.
- Divide result, registered on entry to DONE:
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - -2^31 / -1: quotient 0x80000000, remainder 0.
  - Divisor 0 (either op): HI = operand_1 as issued, LO = 0xFFFFFFFF; same 33-cycle latency.
- DONE:
  - done=1, result = latched {rem,quo}.
  - ex_stall=1: hold in DONE indefinitely.
  - ex_stall=0: go to IDLE at this edge. A new DIV can be issued in the following cycle; no back-to-back issue from DONE.
- flush=1: next state IDLE from any state, counter cleared; done is not asserted for the abandoned divide. flush in IDLE with a DIV op prevents the issue.
- rst has priority over flush; flush has priority over ex_stall and completion.
- A reset or flush mid-division leaves no residue: the next DIV starts fresh.

Test Plan:
1. rst=1 two cycles, then op=NONE -> done=0, busy=0, result=0; MULT 0xFFFFFFFD x 5 -> same cycle done=1, result=0xFFFFFFFF_FFFFFFF1; MULTU same operands -> 0x00000004_FFFFFFF1.
2. MADD hi_in=0, lo_in=0xFFFFFFFF, 2x3 -> result 0x00000001_00000005; MSUBU hi/lo=0, 1x1 -> 0xFFFFFFFF_FFFFFFFF.
3. DIVU 100/7 issued at edge N -> busy cycles N+1..N+32, done=1 first at cycle N+33, result {2, 14}; DIV 0xFFFFFFF9 (-7) / 2 -> {0xFFFFFFFF, 0xFFFFFFFD}.
4. DIV 0x80000000 / 0xFFFFFFFF -> {0, 0x80000000}; DIVU 0x1234 / 0 -> {0x00001234, 0xFFFFFFFF}, both after 33 cycles.
5. DIVU done with ex_stall=1 for 5 cycles -> done and result held stable for all 5; ex_stall=0 -> IDLE next cycle, done=0 with op=NONE.
6. flush at step 10 of a DIV -> IDLE next cycle, done never asserted; immediate DIVU 9/3 -> {0, 3} after a full 33 cycles; rst asserted mid-division behaves the same.
